spi_flash_rd_seq: RTL and testbench

SPI_FLASH_RD_SEQ -- requirements
Module: spi_flash_rd_seq

---
 rtl/spi_seq_pkg.sv | 21 ++
 rtl/wb_single_master.sv | 70 +++++++
 rtl/spi_flash_rd_seq.sv | 200 ++++++++++++++++++++
 tb/tb_spi_flash_rd_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared states, command encodings and register map for the flash read sequencer
package spi_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_OP, S_A2, S_A1, S_A0, S_RD, S_FETCH, S_OUT, S_CS_OFF, S_DONE, S_ERR
  } state_e;

  localparam logic [2:0] ADR_CS_DEF   = 3'd4;
  localparam logic [2:0] ADR_TXD_DEF  = 3'd2;
  localparam logic [2:0] ADR_CMD_DEF  = 3'd3;
  localparam logic [2:0] ADR_RXD_DEF  = 3'd2;

  localparam logic [7:0] CMD_WR_DEF   = 8'h10;
  localparam logic [7:0] CMD_RD_DEF   = 8'h20;
  localparam logic [7:0] CMD_STOP_DEF = 8'h40;
  localparam logic [7:0] OPCODE_DEF   = 8'h03;

  localparam logic [7:0] CS_ASSERT    = 8'hFE;
  localparam logic [7:0] CS_RELEASE   = 8'hFF;

endpackage

// File: rtl/wb_single_master.sv
// rtl/wb_single_master.sv - one-access-at-a-time Wishbone master engine
module wb_single_master (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] dat,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] rdata_q, rdata_d;

  // cyc/stb come straight from a flop, so ack only affects them one cycle later
  always_comb begin
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    if (!cyc_q && start) begin
      cyc_d = 1'b1;
      we_d  = we;
      adr_d = adr;
      dat_d = dat;
    end else if (cyc_q && wbm_ack_i) begin
      cyc_d = 1'b0;
      if (!we_q) rdata_d = wbm_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = cyc_q;
  assign done      = cyc_q & wbm_ack_i;
  assign rdata     = rdata_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cyc_o = cyc_q;

endmodule

// File: rtl/spi_flash_rd_seq.sv
// rtl/spi_flash_rd_seq.sv - drives a Wishbone SPI master through a flash READ and streams the bytes out
module spi_flash_rd_seq
  import spi_seq_pkg::*;
#(
  parameter logic [2:0] ADR_CS   = ADR_CS_DEF,
  parameter logic [2:0] ADR_TXD  = ADR_TXD_DEF,
  parameter logic [2:0] ADR_CMD  = ADR_CMD_DEF,
  parameter logic [2:0] ADR_RXD  = ADR_RXD_DEF,
  parameter logic [7:0] CMD_WR   = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD   = CMD_RD_DEF,
  parameter logic [7:0] CMD_STOP = CMD_STOP_DEF,
  parameter logic [7:0] OPCODE   = OPCODE_DEF,
  parameter logic [7:0] TIP_TMO  = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_i,
  input  logic [23:0] req_addr_i,
  input  logic [15:0] req_len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [2:0]  wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  input  logic [7:0]  wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        tip_i
);

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  tmo_q, tmo_d;

  logic       acc_need, acc_we;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat, tx_byte;
  logic       eng_busy, eng_done;

  // Byte-send states walk four phases: TXD write, CMD write, TIP rise, TIP fall; RD starts at the CMD phase
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    addr_d     = addr_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    acc_need   = 1'b0;
    acc_we     = 1'b1;
    acc_adr    = ADR_CS;
    acc_dat    = CS_RELEASE;
    rd_valid_o = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      S_OP:    tx_byte = OPCODE;
      S_A2:    tx_byte = addr_q[23:16];
      S_A1:    tx_byte = addr_q[15:8];
      S_A0:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d  = req_addr_i;
          len_d   = req_len_i;
          ph_d    = 2'd0;
          state_d = (req_len_i == 16'd0) ? S_DONE : S_CS_ON;
        end
      end
      S_CS_ON: begin
        acc_need = 1'b1;
        acc_dat  = CS_ASSERT;
        if (eng_done) state_d = S_OP;
      end
      S_OP, S_A2, S_A1, S_A0, S_RD: begin
        case (ph_q)
          2'd0: begin
            acc_need = 1'b1;
            acc_adr  = (state_q == S_RD) ? ADR_CMD : ADR_TXD;
            acc_dat  = (state_q == S_RD) ? CMD_RD : tx_byte;
            if (eng_done) begin
              ph_d  = (state_q == S_RD) ? 2'd2 : 2'd1;
              tmo_d = 8'd0;
            end
          end
          2'd1: begin
            acc_need = 1'b1;
            acc_adr  = ADR_CMD;
            acc_dat  = CMD_WR;
            if (eng_done) begin
              ph_d  = 2'd2;
              tmo_d = 8'd0;
            end
          end
          2'd2: begin
            if (tip_i) ph_d = 2'd3;
            else if (tmo_q == TIP_TMO - 8'd1) state_d = S_ERR;
            else tmo_d = tmo_q + 8'd1;
          end
          default: begin
            if (!tip_i) begin
              ph_d = 2'd0;
              case (state_q)
                S_OP:    state_d = S_A2;
                S_A2:    state_d = S_A1;
                S_A1:    state_d = S_A0;
                S_A0:    state_d = S_RD;
                default: state_d = S_FETCH;
              endcase
            end
          end
        endcase
      end
      S_FETCH: begin
        acc_need = 1'b1;
        acc_we   = 1'b0;
        acc_adr  = ADR_RXD;
        acc_dat  = 8'h00;
        if (eng_done) state_d = S_OUT;
      end
      S_OUT: begin
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
          len_d   = len_q - 16'd1;
          ph_d    = 2'd0;
          state_d = (len_q == 16'd1) ? S_CS_OFF : S_RD;
        end
      end
      S_CS_OFF: begin
        acc_need = 1'b1;
        if (ph_q == 2'd0) begin
          acc_adr = ADR_CMD;
          acc_dat = CMD_STOP;
          if (eng_done) ph_d = 2'd1;
        end else if (eng_done) begin
          ph_d    = 2'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        acc_need = 1'b1;
        if (eng_done) begin
          err_o   = 1'b1;
          ph_d    = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ph_q    <= 2'd0;
      addr_q  <= 24'd0;
      len_q   <= 16'd0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);

  wb_single_master u_wb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .start     (acc_need & ~eng_busy),
    .we        (acc_we),
    .adr       (acc_adr),
    .dat       (acc_dat),
    .busy      (eng_busy),
    .done      (eng_done),
    .rdata     (rd_data_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb/tb_spi_flash_rd_seq.sv - scoreboard bench for the flash read sequencer
module tb_spi_flash_rd_seq;

  logic        clk = 1'b0;
  logic        rst, req, busy, done, err, rd_valid, rd_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic [7:0]  rd_data, wdat_o, wdat_i;
  logic [2:0]  wadr;
  logic        wwe, wstb, wcyc, wack, tip;

  int n_cmp = 0, n_fail = 0, cycle = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, cmd_cyc = 0, txd_cnt = 0;
  int byte_idx = 0, stall_left = 0, stall_bus = 0;
  bit tip_en = 1'b1;
  logic [11:0] exp_bus[$];
  logic [7:0]  exp_byte[$];

  spi_flash_rd_seq dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .req_addr_i(req_addr), .req_len_i(req_len),
    .busy_o(busy), .done_o(done), .err_o(err), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready), .wbm_adr_o(wadr), .wbm_dat_o(wdat_o), .wbm_dat_i(wdat_i),
    .wbm_we_o(wwe), .wbm_stb_o(wstb), .wbm_cyc_o(wcyc), .wbm_ack_i(wack), .tip_i(tip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: the full register-access script one read request must produce
  task automatic push_expected(input logic [23:0] a, input logic [15:0] l);
    logic [7:0] b[4];
    b[0] = 8'h03; b[1] = a[23:16]; b[2] = a[15:8]; b[3] = a[7:0];
    exp_bus.push_back({1'b1, 3'd4, 8'hFE});
    for (int i = 0; i < 4; i++) begin
      exp_bus.push_back({1'b1, 3'd2, b[i]});
      exp_bus.push_back({1'b1, 3'd3, 8'h10});
    end
    for (int i = 0; i < int'(l); i++) begin
      exp_bus.push_back({1'b1, 3'd3, 8'h20});
      exp_bus.push_back({1'b0, 3'd2, 8'h00});
    end
    exp_bus.push_back({1'b1, 3'd3, 8'h40});
    exp_bus.push_back({1'b1, 3'd4, 8'hFF});
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (done) done_cnt++;
      if (err) begin err_cnt++; err_cyc = cycle; end
    end
  end

  // Wishbone slave, SPI TIP model and bus scoreboard monitor
  initial begin
    int wait_cnt, tip_st, tip_dly;
    bit in_acc;
    logic [11:0] first, cur, e;
    wack = 1'b0; wdat_i = 8'h00; tip = 1'b0;
    wait_cnt = 0; tip_st = 0; tip_dly = 0; in_acc = 1'b0; first = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        wack = 1'b0; in_acc = 1'b0; tip = 1'b0; tip_st = 0;
      end else begin
        if (tip_st == 1) begin
          if (tip_dly == 0) begin tip = 1'b1; tip_st = 2; tip_dly = $urandom_range(2, 6); end
          else tip_dly--;
        end else if (tip_st == 2) begin
          if (tip_dly == 0) begin tip = 1'b0; tip_st = 0; end
          else tip_dly--;
        end
        if (wack) wack = 1'b0;
        else if (wcyc && wstb) begin
          if (!in_acc) begin in_acc = 1'b1; first = {wwe, wadr, wdat_o}; wait_cnt = $urandom_range(0, 2); end
          if (wait_cnt > 0) wait_cnt--;
          else begin
            wack = 1'b1; in_acc = 1'b0;
            chk("bus_stable", {20'd0, wwe, wadr, wdat_o}, {20'd0, first});
            cur = {wwe, wadr, wwe ? wdat_o : 8'h00};
            if (!wwe) begin wdat_i = 8'($urandom); exp_byte.push_back(wdat_i); end
            if (wwe && wadr == 3'd2) txd_cnt++;
            if (wwe && wadr == 3'd3 && (wdat_o == 8'h10 || wdat_o == 8'h20)) begin
              cmd_cyc = cycle;
              if (tip_en) begin tip_st = 1; tip_dly = $urandom_range(0, 3); end
            end
            if (exp_bus.size() == 0) chk("bus_unexpected", {20'd0, cur}, 32'hFFFFFFFF);
            else begin e = exp_bus.pop_front(); chk("bus_op", {20'd0, cur}, {20'd0, e}); end
          end
        end
      end
    end
  end

  // Byte-stream sink with hold checks and an optional stall window
  initial begin
    bit held_v;
    logic [7:0] held_d;
    held_v = 1'b0; held_d = 8'h00; rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        rd_ready = 1'b0; held_v = 1'b0;
      end else if (rd_valid) begin
        if (held_v) chk("rd_hold", {24'd0, rd_data}, {24'd0, held_d});
        if (stall_left > 0 && byte_idx == 1) begin
          rd_ready = 1'b0; stall_left--;
          if (wcyc) stall_bus++;
        end else rd_ready = ($urandom_range(0, 3) != 0);
        if (rd_ready) begin
          if (exp_byte.size() == 0) chk("rd_unexpected", {24'd0, rd_data}, 32'hFFFFFFFF);
          else chk("rd_byte", {24'd0, rd_data}, {24'd0, exp_byte.pop_front()});
          byte_idx++; held_v = 1'b0;
        end else begin
          held_v = 1'b1; held_d = rd_data;
        end
      end else begin
        if (held_v) chk("rd_valid_drop", 32'd0, 32'd1);
        rd_ready = 1'b0; held_v = 1'b0;
      end
    end
  end

  task automatic issue(input logic [23:0] a, input logic [15:0] l, input bit push);
    if (push && l != 16'd0) push_expected(a, l);
    if (push) byte_idx = 0;
    req = 1'b1; req_addr = a; req_len = l;
    @(posedge clk); #3;
    req = 1'b0;
  endtask

  task automatic wait_end(input string name, input int d0, input int e0, input int dn, input int en);
    int k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 4000) begin
      @(posedge clk); #3;
      k++;
    end
    chk({name, "_timeout"}, (k < 4000), 1);
    repeat (6) begin @(posedge clk); #3; end
    chk({name, "_done_cnt"}, done_cnt - d0, dn);
    chk({name, "_err_cnt"}, err_cnt - e0, en);
    chk({name, "_bus_left"}, exp_bus.size(), 0);
    chk({name, "_bytes_left"}, exp_byte.size(), 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int d0, e0, c0, k;
    rst = 1'b1; req = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);  chk("rst_err", err, 0);
    chk("rst_valid", rd_valid, 0); chk("rst_cyc", wcyc, 0); chk("rst_stb", wstb, 0);
    chk("rst_we", wwe, 0);      chk("rst_adr", wadr, 0);   chk("rst_dat", wdat_o, 0);
    rst = 1'b0;
    @(posedge clk); #3;

    d0 = done_cnt; e0 = err_cnt;
    issue(24'h123456, 16'd3, 1);
    wait_end("basic", d0, e0, 1, 0);

    d0 = done_cnt; e0 = err_cnt; c0 = cycle;
    issue(24'hABCDEF, 16'd0, 1);
    chk("len0_done_pulse", done, 1);
    wait_end("len0", d0, e0, 1, 0);
    chk("len0_busy_cycles", wcyc, 0);

    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt; e0 = err_cnt;
      issue(24'($urandom), 16'($urandom_range(1, 4)), 1);
      wait_end("random", d0, e0, 1, 0);
    end

    d0 = done_cnt; e0 = err_cnt;
    stall_left = 20; stall_bus = 0;
    issue(24'h00F00D, 16'd3, 1);
    wait_end("stall", d0, e0, 1, 0);
    chk("stall_used", stall_left, 0);
    chk("stall_bus_quiet", stall_bus, 0);

    tip_en = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    exp_bus.push_back({1'b1, 3'd4, 8'hFE});
    exp_bus.push_back({1'b1, 3'd2, 8'h03});
    exp_bus.push_back({1'b1, 3'd3, 8'h10});
    exp_bus.push_back({1'b1, 3'd4, 8'hFF});
    byte_idx = 0;
    issue(24'h654321, 16'd2, 0);
    wait_end("tmo", d0, e0, 0, 1);
    chk("tmo_window", ((err_cyc - cmd_cyc) >= 255 && (err_cyc - cmd_cyc) <= 262), 1);
    tip_en = 1'b1;

    d0 = done_cnt; e0 = err_cnt; c0 = txd_cnt;
    issue(24'h445566, 16'd2, 1);
    k = 0;
    while (txd_cnt < c0 + 3 && k < 2000) begin @(posedge clk); #3; k++; end
    chk("rst_a1_reach", (k < 2000), 1);
    rst = 1'b1;
    @(posedge clk); #3;
    chk("rst_a1_cyc", wcyc, 0);
    chk("rst_a1_stb", wstb, 0);
    chk("rst_a1_busy", busy, 0);
    rst = 1'b0;
    exp_bus.delete(); exp_byte.delete();
    chk("rst_a1_no_done", done_cnt - d0, 0);
    d0 = done_cnt; e0 = err_cnt;
    issue(24'h778899, 16'd2, 1);
    wait_end("after_rst", d0, e0, 1, 0);

    d0 = done_cnt; e0 = err_cnt;
    issue(24'h0A0B0C, 16'd2, 1);
    repeat (10) begin @(posedge clk); #3; end
    issue(24'hDEAD00, 16'd5, 0);
    wait_end("busy_ignore", d0, e0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
